// File: rtl/pe_drain_collector.sv
// Drain collector for the systolic array PE column: narrows accumulator results, buffers them
// in a FIFO and streams them out with a per-tile last flag. Define DRAIN_SATURATE_EN to clamp
// instead of truncate when narrowing.
module pe_drain_collector #(
    parameter int DIM   = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             start_i,
    input  logic             drain_valid_i,
    input  logic [ACC_W-1:0] drain_data_i,
    output logic             drain_ready_o,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam int TILE = DIM * DIM;
    localparam int CW   = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int AW   = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]           cnt;
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic signed [OUT_W-1:0] mem_data [DEPTH];
    logic                    mem_last [DEPTH];

    logic full, empty, push, pop, tile_end;
    logic signed [OUT_W-1:0] narrowed;

`ifdef DRAIN_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX)
            c = SAT_MAX;
        else if (v < SAT_MIN)
            c = SAT_MIN;
        else
            c = v;
        return c[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
        return v[OUT_W-1:0];
    endfunction
`endif

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = drain_valid_i & drain_ready_o;
    assign pop      = out_valid_o & out_ready_i;
    assign tile_end = (cnt == CW'(TILE - 1));
    assign narrowed = narrow(drain_data_i);

    always_ff @(posedge clk_i) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = COLLECT;
            COLLECT: if (push && tile_end) state_next = DRAIN;
            DRAIN:   if (pop && out_last_o) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drain_ready_o = (state == COLLECT) && !full;
        busy_o        = (state != IDLE);
    end

    // cnt holds at DIM*DIM-1 after the final accept until the next start clears it.
    always_ff @(posedge clk_i) begin
        if (!reset)
            cnt <= '0;
        else if (state == IDLE && start_i)
            cnt <= '0;
        else if (push && !tile_end)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset)
            overflow_o <= 1'b0;
        else if (state == COLLECT && drain_valid_i && full)
            overflow_o <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= narrowed;
            mem_last[wr_ptr[AW-1:0]] <= tile_end;
        end
    end

    // Head outputs are gated so nothing stale leaks out of an empty FIFO.
    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
    assign out_last_o  = empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_pe_drain_collector.sv
// Directed bench for pe_drain_collector: a queue-based model is checked every cycle,
// plus literal expectations on popped sequences and boundary cases.
module tb_pe_drain_collector;

    localparam int DIM   = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int TILE  = DIM * DIM;

    logic             clk_i = 1'b0;
    logic             reset;
    logic             start_i;
    logic             drain_valid_i;
    logic [ACC_W-1:0] drain_data_i;
    logic             drain_ready_o;
    logic             out_valid_o;
    logic [OUT_W-1:0] out_data_o;
    logic             out_last_o;
    logic             out_ready_i;
    logic             busy_o;
    logic             overflow_o;

    always #5 clk_i = ~clk_i;

    pe_drain_collector #(.DIM(DIM), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .start_i       (start_i),
        .drain_valid_i (drain_valid_i),
        .drain_data_i  (drain_data_i),
        .drain_ready_o (drain_ready_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .out_ready_i   (out_ready_i),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: queue of {last, data}; phase 0=idle, 1=collecting, 2=draining.
    logic [OUT_W:0] mq[$];
    int             ph      = 0;
    int             mcnt    = 0;
    bit             movf    = 1'b0;
    bit             model_on = 1'b0;
    logic [OUT_W:0] plog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_narrow(input logic [ACC_W-1:0] d);
`ifdef DRAIN_SATURATE_EN
        longint v;
        v = longint'($signed(d));
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return d[OUT_W-1:0];
`else
        return d[OUT_W-1:0];
`endif
    endfunction

    always @(posedge clk_i) begin : model
        int ph0;
        bit mfull;
        logic [OUT_W:0] h;
        if (reset && out_valid_o && out_ready_i)
            plog.push_back({out_last_o, out_data_o});
        if (!reset) begin
            mq.delete();
            ph = 0;
            mcnt = 0;
            movf = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            ph0 = ph;
            mfull = (mq.size() == DEPTH);
            if (ph0 == 1 && drain_valid_i && mfull)
                movf = 1'b1;
            if (mq.size() > 0 && out_ready_i) begin
                h = mq.pop_front();
                if (ph0 == 2 && h[OUT_W]) ph = 0;
            end
            if (ph0 == 1 && drain_valid_i && !mfull) begin
                mq.push_back({(mcnt == TILE - 1), model_narrow(drain_data_i)});
                if (mcnt == TILE - 1) ph = 2;
                else mcnt++;
            end
            if (ph0 == 0 && start_i) begin
                ph = 1;
                mcnt = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (model_on) begin
            chk("out_valid", out_valid_o, mq.size() > 0);
            chk("out_data", out_data_o, (mq.size() > 0) ? mq[0][OUT_W-1:0] : '0);
            chk("out_last", out_last_o, (mq.size() > 0) ? mq[0][OUT_W] : 1'b0);
            chk("drain_ready", drain_ready_o, (ph == 1) && (mq.size() < DEPTH));
            chk("busy", busy_o, ph != 0);
            chk("overflow", overflow_o, movf);
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            drain_valid_i = 1'b1;
            drain_data_i  = ACC_W'(base + i);
            @(negedge clk_i);
        end
        drain_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy_o && !out_valid_o) return;
            @(negedge clk_i);
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string name, input int first, input int n, input int last_idx);
        chk({name, "_count"}, plog.size(), n);
        for (int i = 0; i < n && i < plog.size(); i++) begin
            chk({name, "_data"}, plog[i][OUT_W-1:0], OUT_W'(first + i));
            chk({name, "_last"}, plog[i][OUT_W], (i == last_idx));
        end
        plog.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk_i);
        reset = 1'b1;
        plog.delete();
    endtask

    initial begin
        reset         = 1'b0;
        start_i       = 1'b0;
        drain_valid_i = 1'b0;
        drain_data_i  = '0;
        out_ready_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_data", out_data_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", drain_ready_o, 1'b0);
        reset = 1'b1;

        // Test 1: full tile with a ready consumer.
        out_ready_i = 1'b1;
        pulse_start();
        feed(1, 16);
        wait_idle();
        chk("t1_busy", busy_o, 1'b0);
        check_log("t1", 1, 16, 15);

        // Test 2: blocked consumer fills the FIFO and overflows.
        out_ready_i = 1'b0;
        pulse_start();
        feed(1, 16);
        chk("t2_ready", drain_ready_o, 1'b0);
        chk("t2_ovf", overflow_o, 1'b1);
        chk("t2_head", out_data_o, 16'd1);
        chk("t2_occ", mq.size(), 8);
        out_ready_i = 1'b1;
        repeat (8) @(negedge clk_i);
        check_log("t2a", 1, 8, -1);
        feed(9, 8);
        wait_idle();
        check_log("t2b", 9, 8, 7);
        do_reset();

        // Test 3: steady push+pop at 7 entries, two tiles so pointers wrap twice.
        for (int t = 0; t < 2; t++) begin
            out_ready_i = 1'b0;
            pulse_start();
            feed(100 + 100 * t, 7);
            chk("t3_occ_fill", mq.size(), 7);
            out_ready_i = 1'b1;
            for (int i = 0; i < 9; i++) begin
                drain_valid_i = 1'b1;
                drain_data_i  = ACC_W'(107 + 100 * t + i);
                @(negedge clk_i);
                chk("t3_occ", mq.size(), 7);
            end
            drain_valid_i = 1'b0;
            wait_idle();
            check_log("t3", 100 + 100 * t, 16, 15);
        end

        // Test 4: narrowing of out-of-range values.
        out_ready_i = 1'b0;
        pulse_start();
        drain_valid_i = 1'b1;
        drain_data_i  = 32'h0001_2345;
        @(negedge clk_i);
        drain_data_i  = 32'hFFFF_0000;
        @(negedge clk_i);
        drain_valid_i = 1'b0;
`ifdef DRAIN_SATURATE_EN
        chk("t4_pos", out_data_o, 16'h7FFF);
`else
        chk("t4_pos", out_data_o, 16'h2345);
`endif
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
`ifdef DRAIN_SATURATE_EN
        chk("t4_neg", out_data_o, 16'h8000);
`else
        chk("t4_neg", out_data_o, 16'h0000);
`endif
        do_reset();

        // Test 5: reset mid-tile, then a complete tile.
        out_ready_i = 1'b0;
        pulse_start();
        feed(1, 5);
        do_reset();
        chk("t5_valid", out_valid_o, 1'b0);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_ovf", overflow_o, 1'b0);
        out_ready_i = 1'b1;
        pulse_start();
        feed(1, 16);
        wait_idle();
        check_log("t5", 1, 16, 15);

        // Test 6: drain data in IDLE and start during COLLECT are ignored.
        drain_valid_i = 1'b1;
        drain_data_i  = 32'd55;
        repeat (2) @(negedge clk_i);
        drain_valid_i = 1'b0;
        chk("t6_valid", out_valid_o, 1'b0);
        chk("t6_ovf", overflow_o, 1'b0);
        chk("t6_busy", busy_o, 1'b0);
        pulse_start();
        feed(1, 3);
        start_i       = 1'b1;
        drain_valid_i = 1'b1;
        drain_data_i  = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        feed(5, 12);
        wait_idle();
        check_log("t6", 1, 16, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
